// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants.
// ALU operation codes and the hard-wired zero register.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_SUBU = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass select for one source register.
// EX/MEM beats MEM/WB; register zero always reads the file.
module forwarding_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_wreg,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] fwd_data
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  logic hit_exm;
  logic hit_wb;

  assign hit_exm = exm_reg_write &&
                   (exm_wreg != ZERO) &&
                   (exm_wreg == src);
  assign hit_wb  = wb_reg_write &&
                   (wb_wreg != ZERO) &&
                   (wb_wreg == src);

  // pick the youngest in-flight producer
  always_comb begin
    fwd_data = reg_data;
    if (hit_exm)
      fwd_data = exm_result;
    else if (hit_wb)
      fwd_data = wb_data;
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding.
// Also raises load-use stalls toward the front end.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [3:0]        id_alu_control,
  input  logic              id_alu_src,
  input  logic              id_shift_imm,
  input  logic              id_shift_var,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_wreg,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_wreg,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] store_data,
  output logic [REG_AW-1:0] ex_wreg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_hazard
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  typedef struct packed {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wreg;
    logic [3:0]        alu_control;
    logic              alu_src;
    logic              shift_imm;
    logic              shift_var;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;
  id_ex_t bubble;

  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // bubble is an inert add with no side effects
  always_comb begin
    bubble             = '0;
    bubble.alu_control = ALU_ADD;
  end

  // pack the decoded fields for capture
  always_comb begin
    d             = '0;
    d.rs_data     = id_rs_data;
    d.rt_data     = id_rt_data;
    d.imm         = id_imm;
    d.shamt       = id_shamt;
    d.rs          = id_rs;
    d.rt          = id_rt;
    d.wreg        = id_reg_dst ? id_rd : id_rt;
    d.alu_control = id_alu_control;
    d.alu_src     = id_alu_src;
    d.shift_imm   = id_shift_imm;
    d.shift_var   = id_shift_var;
    d.reg_write   = id_reg_write;
    d.mem_read    = id_mem_read;
    d.mem_write   = id_mem_write;
    d.mem_to_reg  = id_mem_to_reg;
  end

  // load-use: the loaded rt is needed by the instruction in ID
  always_comb begin
    load_use_hazard = 1'b0;
    if (!reset && q.mem_read && (q.rt != ZERO))
      load_use_hazard = (id_rs == q.rt) ||
                        (id_uses_rt && (id_rt == q.rt));
  end

  // pipeline register: reset, flush, stall, hazard, load
  always_ff @(posedge clk) begin
    if (reset)
      q <= bubble;
    else if (flush_in)
      q <= bubble;
    else if (stall_in)
      q <= q;
    else if (load_use_hazard)
      q <= bubble;
    else
      q <= d;
  end

  forwarding_unit #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rs (
    .src           (q.rs),
    .reg_data      (q.rs_data),
    .exm_reg_write (exm_reg_write),
    .exm_wreg      (exm_wreg),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_wreg       (wb_wreg),
    .wb_data       (wb_data),
    .fwd_data      (rs_fwd)
  );

  forwarding_unit #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_rt (
    .src           (q.rt),
    .reg_data      (q.rt_data),
    .exm_reg_write (exm_reg_write),
    .exm_wreg      (exm_wreg),
    .exm_result    (exm_result),
    .wb_reg_write  (wb_reg_write),
    .wb_wreg       (wb_wreg),
    .wb_data       (wb_data),
    .fwd_data      (rt_fwd)
  );

  // operand muxes in front of the ALU
  always_comb begin
    alu_a = rs_fwd;
    if (q.shift_imm)
      alu_a = {{(DATA_W-5){1'b0}}, q.shamt};
    else if (q.shift_var)
      alu_a = {{(DATA_W-5){1'b0}}, rs_fwd[4:0]};
    alu_b = q.alu_src ? q.imm : rt_fwd;
  end

  assign store_data    = rt_fwd;
  assign alu_control   = q.alu_control;
  assign ex_wreg       = q.wreg;
  assign ex_reg_write  = q.reg_write;
  assign ex_mem_read   = q.mem_read;
  assign ex_mem_write  = q.mem_write;
  assign ex_mem_to_reg = q.mem_to_reg;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use detection.
- Sits directly upstream of the ALU: captures decoded ID-stage fields each cycle and drives the ALU's a, b and alu_control.
- Also passes store data, destination register and MEM/WB control bits downstream.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB; flags load-use hazards to the front end.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall_in  in  1  hold all registered contents
- flush_in  in  1  load bubble (branch/jump squash)
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign/zero-extended immediate
- id_shamt  in  5  instruction shamt field
- id_rs, id_rt, id_rd  in  REG_AW  register addresses
- id_uses_rt  in  1  instruction reads rt as a source
- id_alu_control  in  4  ALU operation code
- id_alu_src  in  1  1 = operand b is the immediate
- id_shift_imm, id_shift_var  in  1  sll/srl/sra; sllv/srlv/srav
- id_reg_dst  in  1  1 = write rd, 0 = write rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- exm_reg_write  in  1  EX/MEM writes a register
- exm_wreg  in  REG_AW  EX/MEM destination
- exm_result  in  DATA_W  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_wreg  in  REG_AW  MEM/WB destination
- wb_data  in  DATA_W  MEM/WB write-back value
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_control  out  4  registered operation code
- store_data  out  DATA_W  forwarded rt value
- ex_wreg  out  REG_AW  selected destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control
- load_use_hazard  out  1  front end must hold PC and IF/ID

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Register update priority at posedge, highest first:
  - reset → bubble
  - flush_in → bubble
  - stall_in → hold
  - load_use_hazard → bubble
  - otherwise load all id_* fields
- Bubble contents:
  - all data and address fields = 0
  - alu_control = ADD (4'b0010)
  - all control bits = 0
  - a bubble never writes a register or memory
- Latency: id_* captured at edge N, visible on outputs after edge N; forwarding paths are combinational from registered fields and the current exm_*/wb_* inputs.
- Forwarding for each source (rs_q, rt_q):
  - if exm_reg_write and exm_wreg != 0 and exm_wreg == src → exm_result
  - else if wb_reg_write and wb_wreg != 0 and wb_wreg == src → wb_data
  - else the registered read data
  - EX/MEM takes priority when both match
  - register 0 is never forwarded
- alu_a: shift_imm_q → zero-extended shamt_q; shift_var_q → zero-extended forwarded rs[4:0]; else forwarded rs.
- alu_b: alu_src_q → imm_q; else forwarded rt.
- store_data: always the forwarded rt, independent of alu_src.
- ex_wreg: reg_dst_q ? rd_q : rt_q, computed at capture.
- load_use_hazard: asserted combinationally when all of the following hold:
  - ex_mem_read = 1
  - rt_q != 0
  - id_rs == rt_q, or (id_uses_rt and id_rt == rt_q)
  - Deasserted during reset.
- Simultaneous events:
  - flush_in with stall_in → bubble.
  - stall_in with a hazard → hold; the hazard stays asserted and the bubble is inserted on the first unstalled edge.
- Reset mid-stall: bubble on that edge; the stall has no effect.

Decomposition:
- Shared package mips_pkg:
  - ALU op localparams: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_ADDU=0011, ALU_SUBU=0100, ALU_SUB=0110, ALU_SLT=0111, ALU_SLL=1000, ALU_SLTU=1001, ALU_SRL=1010, ALU_SRA=1011, ALU_NOR=1100, ALU_XOR=1101.
  - REG_ZERO constant.
- One sub-module, forwarding_unit: purely combinational select for one source register. Instantiate it twice (rs and rt).

Test Plan:
- Reset: assert reset 2 cycles with id_* non-zero → all outputs 0 except alu_control = 4'b0010; load_use_hazard = 0.
- Capture: add with rs_data = 10, rt_data = 5, reg_dst = 1, rd = 8 → next cycle alu_a = 10, alu_b = 5, alu_control = 0010, ex_wreg = 8.
- Forwarding priority: rs = rt = 3, exm_wreg = 3 with exm_result = 0x11, wb_wreg = 3 with wb_data = 0x22 → alu_a = alu_b = 0x11. Drop exm_reg_write → both 0x22. Set wreg = 0 → read data.
- Shifts:
  - sll with shamt = 3, rt = 1 → alu_a = 3, alu_b = 1.
  - srav with forwarded rs = 0xFFFF_FF23 → alu_a = 3.
  - addi with imm = 0xFFFF_FFF0, rt_data = 7 → alu_b = 0xFFFF_FFF0, store_data = 7.
- Load-use: lw to rt = 4 in stage, id_rs = 4 → hazard = 1; next edge loads a bubble with ex_reg_write = 0; hazard then clears.
- Stall/flush: stall_in held 3 cycles → outputs unchanged. flush_in together with stall_in → bubble.
